mips_alu: RTL and testbench
===========================

// Module: mips_alu
// PURPOSE
//   32-bit integer ALU for the MIPS pipeline EX stage. ALU_result and ALU_zero are a
//   combinational function of the operands, ALU_control and Shampt.
//   MULT and DIV write the architectural Hi/Lo register pair on the rising clock edge.
//   Hi/Lo are the only state in the block.
// PARAMETERS
//   none (datapath fixed at 32 bits; opcodes are package constants)
// PORTS
//   CLK          in   1   system clock, rising-edge
//   RST_N        in   1   reset, synchronous, active-low
//   ALU_IN_1     in   32  operand A (rs), signed two's complement
//   ALU_IN_2     in   32  operand B (rt/imm), signed two's complement
//   ALU_control  in   4   operation select
//   Shampt       in   5   shift amount for SLL/SRL
//   ALU_zero     out  1   1 when ALU_result == 0
//   ALU_result   out  32  combinational result
//   Hi           out  32  Hi register (MULT upper product / DIV remainder)
//   Lo           out  32  Lo register (MULT lower product / DIV quotient)
//   One clock (CLK); reset is synchronous and active-low (RST_N).
// BEHAVIOUR
//   ALU_control encoding (ALU_result, combinational):
//     0000 ADD   A+B, wraps mod 2^32, no overflow trap
//     0100 SUB   A-B, wraps
//     1000 AND   A&B
//     1010 OR    A|B
//     0101 SLT   signed A<B ? 1 : 0
//     0010 SLL   B << Shampt, zero fill
//     0011 SRL   B >> Shampt, logical (zero fill)
//     1001 MUL   low 32 bits of signed A*B; Hi/Lo are not affected
//     1101 MULT  ALU_result=0; {Hi,Lo} <= signed 64-bit A*B at the next CLK edge
//     1011 DIV   ALU_result=0; Lo <= A/B, Hi <= A%B at the next CLK edge
//                signed; quotient truncates toward zero; remainder takes the dividend's sign
//     other codes: ALU_result=0; Hi/Lo hold
//   ALU_zero = (ALU_result == 32'd0) for every code, so MULT/DIV/undefined codes give 1.
//   Hi/Lo update rules:
//     Register updates occur only at the rising CLK edge, with one-cycle latency.
//     Hi/Lo are valid after the edge that samples MULT/DIV.
//     Hi/Lo hold whenever the sampled code is neither MULT nor DIV.
//     DIV with B==0: Hi/Lo hold; no exception.
//     DIV of 0x80000000 by -1: Lo=0x80000000, Hi=0 (wrap).
//   Reset:
//     RST_N==0 at a rising edge sets Hi=Lo=0.
//     Reset has priority over a simultaneous MULT/DIV.
//     ALU_result/ALU_zero stay combinational during reset.
//   Operands and ALU_control may change every cycle; there is no handshake or busy state.
// STRUCTURE
//   Package alu_pkg: ALU_ADD..ALU_DIV 4-bit opcode localparams, XLEN=32.
//   Sub-module alu_muldiv: signed 64-bit product, quotient/remainder and the Hi/Lo
//   registers with reset, hold and div-by-zero handling. Top level holds the
//   combinational result mux and zero detect.
// TESTING
//   A=10, B=5: ADD->15, z0; SUB->5, z0; AND->0, z1; OR->15, z0; SLT->0, z1
//   B=5, Shampt=2: SLL->20; SRL->1. B=0x80000000, SRL by 31 -> 1 (logical)
//   A=10, B=5: DIV edge -> Lo=2, Hi=0; MULT edge -> Hi=0, Lo=50; MUL -> result 50, Hi/Lo hold
//   A=-7, B=2: DIV -> Lo=-3, Hi=-1; A=-1, B=1: MULT -> Hi=Lo=0xFFFFFFFF; SLT A=-1, B=1 -> 1
//   Hi=0, Lo=50; DIV with B=0 -> Hi/Lo unchanged. RST_N=0 during MULT edge -> Hi=Lo=0
//   A=0x7FFFFFFF, B=1: ADD -> 0x80000000 (wrap, no trap)

Source files
------------

// File: rtl/mips_alu_pkg.sv
// alu_pkg: shared constants for the MIPS EX-stage ALU.
//   XLEN      datapath width
//   ALU_*     4-bit ALU_control opcodes
package alu_pkg;
    localparam int XLEN = 32;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0100;
    localparam logic [3:0] ALU_AND  = 4'b1000;
    localparam logic [3:0] ALU_OR   = 4'b1010;
    localparam logic [3:0] ALU_SLT  = 4'b0101;
    localparam logic [3:0] ALU_SLL  = 4'b0010;
    localparam logic [3:0] ALU_SRL  = 4'b0011;
    localparam logic [3:0] ALU_MUL  = 4'b1001;
    localparam logic [3:0] ALU_MULT = 4'b1101;
    localparam logic [3:0] ALU_DIV  = 4'b1011;
endpackage

// File: rtl/mips_alu_if.sv
// mips_alu_if: operand/result bundle between the EX stage and the ALU.
//   ALU_IN_1, ALU_IN_2  operands (signed)
//   ALU_control         opcode
//   Shampt              shift amount
//   ALU_zero            result == 0
//   ALU_result          combinational result
//   Hi, Lo              architectural Hi/Lo registers
// master drives operands and opcode; slave (the ALU) drives results.
interface mips_alu_if;
    import alu_pkg::*;

    logic [XLEN-1:0] ALU_IN_1;
    logic [XLEN-1:0] ALU_IN_2;
    logic [3:0]      ALU_control;
    logic [4:0]      Shampt;
    logic            ALU_zero;
    logic [XLEN-1:0] ALU_result;
    logic [XLEN-1:0] Hi;
    logic [XLEN-1:0] Lo;

    modport master (
        output ALU_IN_1, ALU_IN_2, ALU_control, Shampt,
        input  ALU_zero, ALU_result, Hi, Lo
    );

    modport slave (
        input  ALU_IN_1, ALU_IN_2, ALU_control, Shampt,
        output ALU_zero, ALU_result, Hi, Lo
    );
endinterface

// File: rtl/mips_alu_muldiv.sv
// alu_muldiv: signed multiply/divide and the Hi/Lo register pair.
//   clk, rst_n  clock, synchronous active-low reset
//   a, b        signed operands
//   op          opcode; MULT/DIV update Hi/Lo at the rising edge
//   mul_lo      low word of the signed product (feeds the MUL result)
//   hi, lo      Hi/Lo registers
module alu_muldiv
    import alu_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      op,
    output logic [XLEN-1:0] mul_lo,
    output logic [XLEN-1:0] hi,
    output logic [XLEN-1:0] lo
);
    logic [2*XLEN-1:0] prod;
    logic [XLEN-1:0]   a_mag, b_mag, b_div, q_mag, r_mag, quot, rem;

    // Low 64 bits of the product of sign-extended operands equal the signed product.
    assign prod   = {{XLEN{a[XLEN-1]}}, a} * {{XLEN{b[XLEN-1]}}, b};
    assign mul_lo = prod[XLEN-1:0];

    // Divide on magnitudes, then restore signs: quotient truncates toward zero,
    // remainder follows the dividend. |0x80000000| stays 0x80000000 as unsigned,
    // so INT_MIN / -1 wraps back to 0x80000000 with remainder 0.
    assign a_mag = a[XLEN-1] ? -a : a;
    assign b_mag = b[XLEN-1] ? -b : b;
    assign b_div = (b == '0) ? XLEN'(1) : b_mag;   // keeps the divider defined; result unused
    assign q_mag = a_mag / b_div;
    assign r_mag = a_mag % b_div;
    assign quot  = (a[XLEN-1] ^ b[XLEN-1]) ? -q_mag : q_mag;
    assign rem   = a[XLEN-1] ? -r_mag : r_mag;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            hi <= '0;
            lo <= '0;
        end else if (op == ALU_MULT) begin
            {hi, lo} <= prod;
        end else if (op == ALU_DIV && b != '0) begin
            hi <= rem;
            lo <= quot;
        end
    end
endmodule

// File: rtl/mips_alu.sv
// mips_alu: 32-bit integer ALU for the EX stage.
//   CLK, RST_N  clock, synchronous active-low reset (clears Hi/Lo only)
//   bus         mips_alu_if.slave: operands, opcode, shift amount in;
//               combinational result/zero and registered Hi/Lo out
module mips_alu
    import alu_pkg::*;
(
    input  logic     CLK,
    input  logic     RST_N,
    mips_alu_if.slave bus
);
    logic [XLEN-1:0] a, b, mul_lo, result, hi, lo;
    logic            slt;

    assign a   = bus.ALU_IN_1;
    assign b   = bus.ALU_IN_2;
    assign slt = $signed(a) < $signed(b);

    alu_muldiv u_muldiv (
        .clk    (CLK),
        .rst_n  (RST_N),
        .a      (a),
        .b      (b),
        .op     (bus.ALU_control),
        .mul_lo (mul_lo),
        .hi     (hi),
        .lo     (lo)
    );

    // MULT, DIV and undefined codes fall through to zero.
    always_comb begin
        result = '0;
        case (bus.ALU_control)
            ALU_ADD: result = a + b;
            ALU_SUB: result = a - b;
            ALU_AND: result = a & b;
            ALU_OR:  result = a | b;
            ALU_SLT: result = {{(XLEN-1){1'b0}}, slt};
            ALU_SLL: result = b << bus.Shampt;
            ALU_SRL: result = b >> bus.Shampt;
            ALU_MUL: result = mul_lo;
            default: result = '0;
        endcase
    end

    assign bus.ALU_result = result;
    assign bus.ALU_zero   = (result == '0);
    assign bus.Hi         = hi;
    assign bus.Lo         = lo;
endmodule

// File: tb/tb_mips_alu.sv
module tb_mips_alu;
    import alu_pkg::*;

    typedef struct {
        logic        rst_n;
        logic [3:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  sh;
        logic [31:0] res;
        logic        zero;
        logic [31:0] hi;   // Hi/Lo after the edge that samples this vector
        logic [31:0] lo;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic        zero;
        logic [31:0] hi;
        logic [31:0] lo;
    } exp_t;

    logic CLK = 1'b0;
    logic RST_N;
    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];
    logic [31:0] m_hi, m_lo;

    mips_alu_if bus ();

    mips_alu dut (
        .CLK   (CLK),
        .RST_N (RST_N),
        .bus   (bus.slave)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, req);
        end
    endtask

    // Independent reference: 64-bit integer arithmetic.
    task automatic model(input logic rst_n, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] sh, output exp_t e);
        int    ia, ib;
        longint sa, sb, p, q, r;
        ia = a; ib = b; sa = ia; sb = ib;
        e.res = 32'd0;
        case (op)
            ALU_ADD: e.res = a + b;
            ALU_SUB: e.res = a - b;
            ALU_AND: e.res = a & b;
            ALU_OR:  e.res = a | b;
            ALU_SLT: e.res = (ia < ib) ? 32'd1 : 32'd0;
            ALU_SLL: e.res = a * 0 + (b << sh);
            ALU_SRL: e.res = b >> sh;
            ALU_MUL: begin p = sa * sb; e.res = p[31:0]; end
            default: e.res = 32'd0;
        endcase
        e.zero = (e.res == 32'd0);
        if (!rst_n) begin
            m_hi = 0; m_lo = 0;
        end else if (op == ALU_MULT) begin
            p = sa * sb; m_hi = p[63:32]; m_lo = p[31:0];
        end else if (op == ALU_DIV && b != 0) begin
            q = sa / sb; r = sa % sb; m_lo = q[31:0]; m_hi = r[31:0];
        end
        e.hi = m_hi; e.lo = m_lo;
    endtask

    // Drive one vector, push its expectation, then check result/zero before the
    // edge and Hi/Lo just after it.
    task automatic apply(input string name, input logic rst_n, input logic [3:0] op,
                         input logic [31:0] a, input logic [31:0] b, input logic [4:0] sh,
                         input exp_t e);
        exp_t got;
        @(negedge CLK);
        RST_N = rst_n; bus.ALU_control = op; bus.ALU_IN_1 = a; bus.ALU_IN_2 = b; bus.Shampt = sh;
        sb_q.push_back(e);
        #1;
        if (sb_q.size() == 0) begin
            total++; bad++;
            $display("FAIL %s: scoreboard empty", name);
            return;
        end
        got = sb_q.pop_front();
        chk({name, ".res"},  bus.ALU_result, got.res);
        chk({name, ".zero"}, {31'd0, bus.ALU_zero}, {31'd0, got.zero});
        @(posedge CLK); #1;
        chk({name, ".hi"}, bus.Hi, got.hi);
        chk({name, ".lo"}, bus.Lo, got.lo);
    endtask

    vec_t tbl[$];
    exp_t e;

    initial begin
        RST_N = 1'b0; bus.ALU_control = ALU_ADD; bus.ALU_IN_1 = 0; bus.ALU_IN_2 = 0; bus.Shampt = 0;
        m_hi = 0; m_lo = 0;

        //        rst  op        a             b             sh  res           z  hi            lo
        tbl = '{
            '{1'b0, ALU_ADD,  32'd10,       32'd5,        5'd0, 32'd15,       0, 32'd0,        32'd0},
            '{1'b1, ALU_ADD,  32'd10,       32'd5,        5'd0, 32'd15,       0, 32'd0,        32'd0},
            '{1'b1, ALU_SUB,  32'd10,       32'd5,        5'd0, 32'd5,        0, 32'd0,        32'd0},
            '{1'b1, ALU_AND,  32'd10,       32'd5,        5'd0, 32'd0,        1, 32'd0,        32'd0},
            '{1'b1, ALU_OR,   32'd10,       32'd5,        5'd0, 32'd15,       0, 32'd0,        32'd0},
            '{1'b1, ALU_SLT,  32'd10,       32'd5,        5'd0, 32'd0,        1, 32'd0,        32'd0},
            '{1'b1, ALU_SLL,  32'd0,        32'd5,        5'd2, 32'd20,       0, 32'd0,        32'd0},
            '{1'b1, ALU_SRL,  32'd0,        32'd5,        5'd2, 32'd1,        0, 32'd0,        32'd0},
            '{1'b1, ALU_SRL,  32'd0,        32'h80000000, 5'd31,32'd1,        0, 32'd0,        32'd0},
            '{1'b1, ALU_DIV,  32'd10,       32'd5,        5'd0, 32'd0,        1, 32'd0,        32'd2},
            '{1'b1, ALU_MULT, 32'd10,       32'd5,        5'd0, 32'd0,        1, 32'd0,        32'd50},
            '{1'b1, ALU_MUL,  32'd10,       32'd5,        5'd0, 32'd50,       0, 32'd0,        32'd50},
            '{1'b1, ALU_DIV,  32'd10,       32'd0,        5'd0, 32'd0,        1, 32'd0,        32'd50},
            '{1'b1, 4'b1111,  32'd3,        32'd4,        5'd0, 32'd0,        1, 32'd0,        32'd50},
            '{1'b1, ALU_DIV,  -32'sd7,      32'd2,        5'd0, 32'd0,        1, 32'hFFFFFFFF, 32'hFFFFFFFD},
            '{1'b1, ALU_MULT, 32'hFFFFFFFF, 32'd1,        5'd0, 32'd0,        1, 32'hFFFFFFFF, 32'hFFFFFFFF},
            '{1'b1, ALU_SLT,  32'hFFFFFFFF, 32'd1,        5'd0, 32'd1,        0, 32'hFFFFFFFF, 32'hFFFFFFFF},
            '{1'b1, ALU_DIV,  32'h80000000, 32'hFFFFFFFF, 5'd0, 32'd0,        1, 32'd0,        32'h80000000},
            '{1'b1, ALU_ADD,  32'h7FFFFFFF, 32'd1,        5'd0, 32'h80000000, 0, 32'd0,        32'h80000000},
            '{1'b1, ALU_MULT, 32'h7FFFFFFF, 32'h7FFFFFFF, 5'd0, 32'd0,        1, 32'h3FFFFFFF, 32'h00000001},
            '{1'b1, ALU_MULT, 32'd10,       32'd5,        5'd0, 32'd0,        1, 32'd50 * 0,   32'd50},
            '{1'b0, ALU_MULT, 32'd10,       32'd5,        5'd0, 32'd0,        1, 32'd0,        32'd0}
        };

        // Reset state after the first edge with RST_N low.
        @(posedge CLK); #1;
        chk("reset.hi", bus.Hi, 32'd0);
        chk("reset.lo", bus.Lo, 32'd0);

        for (int i = 0; i < tbl.size(); i++) begin
            e.res = tbl[i].res; e.zero = tbl[i].zero; e.hi = tbl[i].hi; e.lo = tbl[i].lo;
            apply($sformatf("vec%0d", i), tbl[i].rst_n, tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].sh, e);
        end

        // Hand sequence: MULT then reset-with-DIV, then hold across a non-muldiv op.
        m_hi = 0; m_lo = 0;
        model(1'b1, ALU_MULT, 32'hFFFF0000, 32'h00010000, 5'd0, e);
        apply("seq.mult", 1'b1, ALU_MULT, 32'hFFFF0000, 32'h00010000, 5'd0, e);
        model(1'b0, ALU_DIV, 32'd100, 32'd7, 5'd0, e);
        apply("seq.rstdiv", 1'b0, ALU_DIV, 32'd100, 32'd7, 5'd0, e);
        model(1'b1, ALU_DIV, 32'd100, -32'sd7, 5'd0, e);
        apply("seq.div", 1'b1, ALU_DIV, 32'd100, -32'sd7, 5'd0, e);
        model(1'b1, ALU_SUB, 32'd3, 32'd3, 5'd0, e);
        apply("seq.hold", 1'b1, ALU_SUB, 32'd3, 32'd3, 5'd0, e);

        // Random sweep through the reference model.
        for (int i = 0; i < 40; i++) begin
            logic [3:0]  op;
            logic [31:0] a, b;
            logic [4:0]  sh;
            case ($urandom_range(0, 10))
                0: op = ALU_ADD;  1: op = ALU_SUB;  2: op = ALU_AND;  3: op = ALU_OR;
                4: op = ALU_SLT;  5: op = ALU_SLL;  6: op = ALU_SRL;  7: op = ALU_MUL;
                8: op = ALU_MULT; 9: op = ALU_DIV;  default: op = 4'b0111;
            endcase
            a  = $urandom();
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom();
            sh = 5'($urandom_range(0, 31));
            model(1'b1, op, a, b, sh, e);
            apply($sformatf("rnd%0d", i), 1'b1, op, a, b, sh, e);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1);
    end
endmodule
